// File: rtl/bip_program_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : bip_program_loader_if
// Purpose  : Bundles the signals between the BIP program loader and the blocks
//            around it: the UART RX byte strobe, the program-memory write
//            port and the load-status flags seen by the BIP top.
// Signals  : i_start        arm a load (one-cycle pulse)
//            i_rx_data      received byte
//            i_rx_valid     byte strobe, one cycle
//            o_pm_wr_en     program memory write enable
//            o_pm_addr      program memory write address
//            o_pm_data      program memory write data
//            o_cpu_hold     CPU held in reset while high
//            o_done         load finished successfully
//            o_error        load aborted on low-byte timeout
//            o_word_count   words written in the current or last load
// Modports : slave  - the loader itself
//            master - the surrounding logic driving bytes and start
// Revision : 1.0 - initial release
// ============================================================================
interface bip_program_loader_if #(
  parameter int NB_BYTE   = 8,
  parameter int NB_ADDR   = 11,
  parameter int RAM_WIDTH = 16
);
  logic                 i_start;
  logic [NB_BYTE-1:0]   i_rx_data;
  logic                 i_rx_valid;
  logic                 o_pm_wr_en;
  logic [NB_ADDR-1:0]   o_pm_addr;
  logic [RAM_WIDTH-1:0] o_pm_data;
  logic                 o_cpu_hold;
  logic                 o_done;
  logic                 o_error;
  logic [NB_ADDR:0]     o_word_count;

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_pm_wr_en, o_pm_addr, o_pm_data, o_cpu_hold, o_done, o_error,
           o_word_count
  );

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_pm_wr_en, o_pm_addr, o_pm_data, o_cpu_hold, o_done, o_error,
           o_word_count
  );
endinterface
`default_nettype wire

// File: rtl/bip_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : bip_program_loader
// Purpose  : Assembles UART bytes (MSB first) into instructions and writes
//            them to consecutive program-memory addresses from 0, holding the
//            CPU in reset until a HALT word or the last address is written.
// Ports    : i_clk  - clock, rising edge
//            i_rst  - asynchronous reset, active low
//            bus    - bip_program_loader_if.slave (start, RX bytes, memory
//                     write port, hold/done/error flags, word count)
// Revision : 1.0 - initial release
// ============================================================================
module bip_program_loader #(
  parameter int                 RAM_WIDTH      = 16,
  parameter int                 NB_ADDR        = 11,
  parameter int                 NB_BYTE        = 8,
  parameter int                 NB_OPCODE      = 5,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = 5'b00000,
  parameter int                 NB_TIMEOUT     = 22,
  parameter int                 TIMEOUT_CYCLES = 2000000
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst,
  bip_program_loader_if.slave    bus
);

  localparam logic [NB_TIMEOUT-1:0] c_timeout_last = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [NB_ADDR:0]      c_count_one    = (NB_ADDR+1)'(1);
  localparam logic [NB_ADDR-1:0]    c_addr_one     = NB_ADDR'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_HI = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t                 r_state;
  logic [NB_BYTE-1:0]     r_hi_byte;
  logic [NB_TIMEOUT-1:0]  r_timeout;
  logic                   r_pm_wr_en;
  logic [NB_ADDR-1:0]     r_pm_addr;
  logic [RAM_WIDTH-1:0]   r_pm_data;
  logic                   r_cpu_hold;
  logic                   r_done;
  logic                   r_error;
  logic [NB_ADDR:0]       r_word_count;

  logic w_halt_word;
  logic w_last_addr;
  logic w_terminate;

  // The word being written is in r_pm_data during WRITE, so the termination
  // decision is made from the registered copy.
  assign w_halt_word = (r_pm_data[RAM_WIDTH-1 -: NB_OPCODE] == HALT_OPCODE);
  assign w_last_addr = &r_pm_addr;
  assign w_terminate = w_halt_word | w_last_addr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_hi_byte    <= '0;
      r_timeout    <= '0;
      r_pm_wr_en   <= 1'b0;
      r_pm_addr    <= '0;
      r_pm_data    <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_pm_wr_en <= 1'b0;
      case (r_state)
        // Idle, finished and failed loads all re-arm the same way.
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.i_start) begin
            r_state      <= ST_WAIT_HI;
            r_pm_addr    <= '0;
            r_word_count <= '0;
            r_error      <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_hold   <= 1'b1;
          end
        end

        ST_WAIT_HI: begin
          if (bus.i_rx_valid) begin
            r_hi_byte <= bus.i_rx_data;
            r_timeout <= '0;
            r_state   <= ST_WAIT_LO;
          end
        end

        // A byte arriving on the expiry cycle still completes the word.
        ST_WAIT_LO: begin
          if (bus.i_rx_valid) begin
            r_pm_data  <= {r_hi_byte, bus.i_rx_data};
            r_pm_wr_en <= 1'b1;
            r_state    <= ST_WRITE;
          end else if (r_timeout == c_timeout_last) begin
            r_error <= 1'b1;
            r_state <= ST_ERROR;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end

        // Single write cycle. A byte strobed here is already the next high
        // byte unless this word ends the load, in which case it is dropped.
        ST_WRITE: begin
          r_word_count <= r_word_count + c_count_one;
          if (w_terminate) begin
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_state    <= ST_DONE;
          end else begin
            r_pm_addr <= r_pm_addr + c_addr_one;
            if (bus.i_rx_valid) begin
              r_hi_byte <= bus.i_rx_data;
              r_timeout <= '0;
              r_state   <= ST_WAIT_LO;
            end else begin
              r_state <= ST_WAIT_HI;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_pm_wr_en   = r_pm_wr_en;
  assign bus.o_pm_addr    = r_pm_addr;
  assign bus.o_pm_data    = r_pm_data;
  assign bus.o_cpu_hold   = r_cpu_hold;
  assign bus.o_done       = r_done;
  assign bus.o_error      = r_error;
  assign bus.o_word_count = r_word_count;

endmodule
`default_nettype wire
